// File: rtl/rom_line_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : rom_line_sched_if
//  Description : Signal bundle between the ROM line scheduler, its two job
//                requesters (A-matrix loader = 0, B-matrix loader = 1) and
//                the line ROM.
//  Modports    : master - scheduler side (drives grant/status/ROM request)
//                slave  - requester + ROM side (drives jobs and ROM status)
//  Signals     : req, base0/1, nlines0/1          job requests
//                gnt, busy, done, done_id         job status
//                line_vld, line_idx               returned-line flags
//                rom_fetch, rom_addr(_use_ext)    ROM request
//                rom_ready, rom_line_valid        ROM status
//                err                              only with
//                                                 ROM_LINE_SCHED_TIMEOUT_EN
//  Revision    : 1.0 - initial release
// ============================================================================
interface rom_line_sched_if #(
  parameter int AW = 8,
  parameter int CW = 8
) ();
  logic [1:0]    req;
  logic [AW-1:0] base0;
  logic [AW-1:0] base1;
  logic [CW-1:0] nlines0;
  logic [CW-1:0] nlines1;
  logic [1:0]    gnt;
  logic          busy;
  logic          done;
  logic          done_id;
  logic [1:0]    line_vld;
  logic [CW-1:0] line_idx;
  logic          rom_fetch;
  logic          rom_addr_use_ext;
  logic [AW-1:0] rom_addr;
  logic          rom_ready;
  logic          rom_line_valid;
`ifdef ROM_LINE_SCHED_TIMEOUT_EN
  logic          err;
`endif

  modport master (
    input  req, base0, base1, nlines0, nlines1, rom_ready, rom_line_valid,
    output gnt, busy, done, done_id, line_vld, line_idx,
`ifdef ROM_LINE_SCHED_TIMEOUT_EN
    output err,
`endif
    output rom_fetch, rom_addr_use_ext, rom_addr
  );

  modport slave (
    output req, base0, base1, nlines0, nlines1, rom_ready, rom_line_valid,
    input  gnt, busy, done, done_id, line_vld, line_idx,
`ifdef ROM_LINE_SCHED_TIMEOUT_EN
    input  err,
`endif
    input  rom_fetch, rom_addr_use_ext, rom_addr
  );
endinterface
`default_nettype wire

// File: rtl/rom_line_sched.sv
`default_nettype none
// ============================================================================
//  Module      : rom_line_sched
//  Description : Round-robin job scheduler feeding a line-organised ROM.
//                A granted job fetches nlines lines starting at base with a
//                stride of LINE_LEN words, one fetch outstanding at a time.
//  Ports       : clk    - clock, rising edge
//                rst_n  - asynchronous active-low reset
//                bus    - rom_line_sched_if.master (jobs, status, ROM side)
//  Parameters  : AW (ROM address width), LINE_LEN (address stride),
//                CW (line-count width)
//  Option      : ROM_LINE_SCHED_TIMEOUT_EN - adds a 4-bit WAIT watchdog and
//                the err output; without it WAIT waits indefinitely.
//  Revision    : 1.0 - initial release
// ============================================================================
module rom_line_sched #(
  parameter int AW       = 8,
  parameter int LINE_LEN = 16,
  parameter int CW       = 8
) (
  input wire               clk,
  input wire               rst_n,
  rom_line_sched_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [1:0]    r_gnt;
  logic          r_owner;
  logic          r_last;      // requester granted most recently
  logic [AW-1:0] r_addr;
  logic [CW-1:0] r_nlines;
  logic [CW-1:0] r_k;

  logic          w_pick;
  logic [CW-1:0] w_k_inc;
  logic          w_more;
  logic          w_busy;
  logic          w_fetch;
  logic          w_done;
  logic [1:0]    w_line_vld;

  // On a tie the requester that did not win last time gets the job.
  assign w_pick  = (bus.req == 2'b11) ? ~r_last : bus.req[1];
  // k never exceeds nlines-1, so k+1 cannot overflow CW bits.
  assign w_k_inc = r_k + CW'(1);
  assign w_more  = (w_k_inc < r_nlines);

`ifdef ROM_LINE_SCHED_TIMEOUT_EN
  logic [3:0] r_tmo;
  logic       w_tmo_hit;

  // The edge that would take the counter to 15 is the one that leaves WAIT.
  assign w_tmo_hit = (r_tmo == 4'd14) && !bus.rom_line_valid;

  // Counter is kept through DONE so err can be derived from it there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo <= 4'd0;
    end else if (r_state == S_WAIT) begin
      if (!bus.rom_line_valid) r_tmo <= r_tmo + 4'd1;
    end else if (r_state != S_DONE) begin
      r_tmo <= 4'd0;
    end
  end

  assign bus.err = (r_state == S_DONE) && (r_tmo == 4'd15);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b1;
    w_fetch     = 1'b0;
    w_done      = 1'b0;
    w_line_vld  = 2'b00;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (|bus.req) begin
          // A zero-length job completes without touching the ROM.
          if ((w_pick ? bus.nlines1 : bus.nlines0) == '0) w_state_nxt = S_DONE;
          else                                            w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_fetch = 1'b1;
        if (bus.rom_ready) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_line_vld = r_gnt & {2{bus.rom_line_valid}};
        if (bus.rom_line_valid) begin
          w_state_nxt = w_more ? S_ISSUE : S_DONE;
        end
`ifdef ROM_LINE_SCHED_TIMEOUT_EN
        else if (w_tmo_hit) begin
          w_state_nxt = S_DONE;
        end
`endif
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Job context: latched at grant, advanced per returned line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt    <= 2'b00;
      r_owner  <= 1'b0;
      r_last   <= 1'b1;   // makes requester 0 win the first tie
      r_addr   <= '0;
      r_nlines <= '0;
      r_k      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|bus.req) begin
            r_gnt    <= w_pick ? 2'b10 : 2'b01;
            r_owner  <= w_pick;
            r_last   <= w_pick;
            r_addr   <= w_pick ? bus.base1 : bus.base0;
            r_nlines <= w_pick ? bus.nlines1 : bus.nlines0;
            r_k      <= '0;
          end
        end
        S_WAIT: begin
          if (bus.rom_line_valid && w_more) begin
            r_k    <= w_k_inc;
            r_addr <= r_addr + AW'(LINE_LEN);  // wraps modulo 2^AW
          end
        end
        S_DONE: r_gnt <= 2'b00;
        default: ;
      endcase
    end
  end

  assign bus.gnt              = r_gnt;
  assign bus.busy             = w_busy;
  assign bus.done             = w_done;
  assign bus.done_id          = w_done & r_owner;
  assign bus.line_vld         = w_line_vld;
  assign bus.line_idx         = r_k;
  assign bus.rom_fetch        = w_fetch;
  assign bus.rom_addr_use_ext = 1'b1;
  assign bus.rom_addr         = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_rom_line_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rom_line_sched
//  Description : Self-checking bench for rom_line_sched. Directed scenarios
//                followed by randomized jobs; expected behaviour comes from a
//                job-level model (round-robin by last winner, address
//                base + k*LINE_LEN mod 2^AW, 2 cycles per line plus stalls).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_line_sched;
  localparam int AW       = 8;
  localparam int CW       = 8;
  localparam int LINE_LEN = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rom_line_sched_if #(.AW(AW), .CW(CW)) bus ();

  rom_line_sched #(.AW(AW), .LINE_LEN(LINE_LEN), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Job-level model state
  bit            pend[2];
  logic [AW-1:0] jbase[2];
  int            jn[2];
  int            last;   // index of the requester granted most recently

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.req     = {pend[1], pend[0]};
    bus.base0   = jbase[0];
    bus.base1   = jbase[1];
    bus.nlines0 = CW'(jn[0]);
    bus.nlines1 = CW'(jn[1]);
  endtask

  task automatic setjob(input int r, input logic [AW-1:0] b, input int n);
    pend[r]  = 1'b1;
    jbase[r] = b;
    jn[r]    = n;
  endtask

  // The owner's job fields are don't-care once granted.
  task automatic scramble(input int w);
    if (w == 0) begin
      bus.base0 = AW'($urandom); bus.nlines0 = CW'($urandom);
    end else begin
      bus.base1 = AW'($urandom); bus.nlines1 = CW'($urandom);
    end
  endtask

  // Called at a negedge with the DUT in IDLE and requests already driven.
  task automatic serve(input int smin, input int smax, input int lmin, input int lmax);
    int w, n, s, l;
    logic [AW-1:0] b;
    w = (pend[0] && pend[1]) ? 1 - last : (pend[1] ? 1 : 0);
    b = jbase[w];
    n = jn[w];
    #1;
    chk("idle_busy", 32'(bus.busy), 0);
    chk("idle_gnt", 32'(bus.gnt), 0);
    chk("idle_fetch", 32'(bus.rom_fetch), 0);
    @(posedge clk);
    last = w;
    for (int k = 0; k < n; k++) begin
      s = $urandom_range(smax, smin);
      l = $urandom_range(lmax, lmin);
      for (int c = 0; c <= s; c++) begin
        @(negedge clk);
        scramble(w);
        bus.rom_ready      = (c == s);
        bus.rom_line_valid = 1'b0;
        #1;
        chk("issue_fetch", 32'(bus.rom_fetch), 1);
        chk("issue_addr", 32'(bus.rom_addr), 32'((int'(b) + k * LINE_LEN) % (1 << AW)));
        chk("issue_gnt", 32'(bus.gnt), 32'(1 << w));
        chk("issue_lvld", 32'(bus.line_vld), 0);
        chk("issue_done", 32'(bus.done), 0);
        @(posedge clk);
      end
      for (int c = 0; c <= l; c++) begin
        @(negedge clk);
        scramble(w);
        bus.rom_ready      = 1'($urandom);
        bus.rom_line_valid = (c == l);
        #1;
        chk("wait_fetch", 32'(bus.rom_fetch), 0);
        chk("wait_busy", 32'(bus.busy), 1);
        chk("wait_done", 32'(bus.done), 0);
        chk("wait_lvld", 32'(bus.line_vld), (c == l) ? 32'(1 << w) : 0);
        if (c == l) chk("wait_lidx", 32'(bus.line_idx), 32'(k));
        @(posedge clk);
      end
    end
    @(negedge clk);
    bus.rom_ready      = 1'b0;
    bus.rom_line_valid = 1'b0;
    pend[w]            = 1'b0;
    bus.req[w]         = 1'b0;
    #1;
    chk("done", 32'(bus.done), 1);
    chk("done_id", 32'(bus.done_id), 32'(w));
    chk("done_gnt", 32'(bus.gnt), 32'(1 << w));
    chk("done_fetch", 32'(bus.rom_fetch), 0);
    chk("done_lvld", 32'(bus.line_vld), 0);
`ifdef ROM_LINE_SCHED_TIMEOUT_EN
    chk("done_err", 32'(bus.err), 0);
`endif
    @(posedge clk);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n   = 1'b0;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    drive();
    bus.rom_ready      = 1'b0;
    bus.rom_line_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    last  = 1;
  endtask

  // Grant a single job and get its first fetch accepted; ends in WAIT.
  task automatic start_to_wait(input int r, input logic [AW-1:0] b, input int n);
    @(negedge clk);
    setjob(r, b, n);
    drive();
    @(posedge clk);
    last = r;
    @(negedge clk);
    bus.rom_ready = 1'b1;
    #1;
    chk("sw_fetch", 32'(bus.rom_fetch), 1);
    chk("sw_addr", 32'(bus.rom_addr), 32'(b));
    @(posedge clk);
    @(negedge clk);
    bus.rom_ready = 1'b0;
  endtask

  initial begin
    rst_n              = 1'b0;
    pend[0]            = 1'b0;
    pend[1]            = 1'b0;
    jbase[0]           = '0;
    jbase[1]           = '0;
    jn[0]              = 0;
    jn[1]              = 0;
    last               = 1;
    drive();
    bus.rom_ready      = 1'b0;
    bus.rom_line_valid = 1'b0;
    #1;
    chk("rst_gnt", 32'(bus.gnt), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_done_id", 32'(bus.done_id), 0);
    chk("rst_fetch", 32'(bus.rom_fetch), 0);
    chk("rst_use_ext", 32'(bus.rom_addr_use_ext), 1);
    chk("rst_addr", 32'(bus.rom_addr), 0);
    chk("rst_lvld", 32'(bus.line_vld), 0);
    chk("rst_lidx", 32'(bus.line_idx), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Single 3-line job, zero stall: lines 0x10/0x20/0x30, done 2n edges after grant.
    @(negedge clk); setjob(0, 8'h10, 3); drive(); serve(0, 0, 0, 0);

    // Tie from reset: 0, then 1, then the next tie goes to 0.
    reset_pulse();
    setjob(0, 8'h01, 1); setjob(1, 8'h02, 1); drive(); serve(0, 0, 0, 0);
    @(negedge clk); drive(); serve(0, 0, 0, 0);
    @(negedge clk); setjob(0, 8'h03, 1); setjob(1, 8'h04, 1); drive(); serve(0, 0, 0, 0);
    @(negedge clk); drive(); serve(0, 0, 0, 0);

    // Address wrap.
    @(negedge clk); setjob(1, 8'hF0, 2); drive(); serve(0, 0, 0, 0);
    // ISSUE stalled 4 cycles.
    @(negedge clk); setjob(0, 8'h55, 2); drive(); serve(4, 4, 0, 0);
    // Zero-length job.
    @(negedge clk); setjob(0, 8'h77, 0); drive(); serve(0, 0, 0, 0);

    // Randomized jobs.
    for (int it = 0; it < 50; it++) begin
      @(negedge clk);
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(3, 0) != 0)
          setjob(r, AW'($urandom), $urandom_range(4, 0));
      end
      drive();
      if (pend[0] || pend[1]) begin
        serve(0, 3, 0, 3);
      end else begin
        #1;
        chk("rand_idle_busy", 32'(bus.busy), 0);
        @(posedge clk);
      end
    end
    for (int d = 0; d < 2; d++) begin
      if (pend[0] || pend[1]) begin
        @(negedge clk); drive(); serve(0, 0, 0, 0);
      end
    end

    // Reset during ISSUE: rom_fetch drops with no clock edge.
    @(negedge clk); setjob(0, 8'h40, 3); drive();
    @(posedge clk);
    @(negedge clk);
    bus.rom_ready = 1'b0;
    #1;
    chk("mid_issue_fetch", 32'(bus.rom_fetch), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_fetch", 32'(bus.rom_fetch), 0);
    chk("async_rst_busy", 32'(bus.busy), 0);
    chk("async_rst_gnt", 32'(bus.gnt), 0);
    @(negedge clk);
    pend[0] = 1'b0; drive(); rst_n = 1'b1; last = 1;

    // Reset during WAIT with a line arriving: nothing flagged, no done later.
    start_to_wait(1, 8'h20, 3);
    bus.rom_line_valid = 1'b1;
    #1;
    chk("mid_wait_lvld", 32'(bus.line_vld), 32'b10);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wait_lvld", 32'(bus.line_vld), 0);
    chk("rst_wait_busy", 32'(bus.busy), 0);
    @(negedge clk);
    pend[1] = 1'b0; drive(); bus.rom_line_valid = 1'b0; rst_n = 1'b1; last = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      chk("post_rst_done", 32'(bus.done), 0);
      chk("post_rst_busy", 32'(bus.busy), 0);
    end

    // rom_line_valid withheld in WAIT.
    start_to_wait(1, 8'h33, 2);
    for (int c = 0; c < 15; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      chk("hold_busy", 32'(bus.busy), 1);
      chk("hold_done", 32'(bus.done), 0);
      chk("hold_fetch", 32'(bus.rom_fetch), 0);
      @(posedge clk);
    end
`ifdef ROM_LINE_SCHED_TIMEOUT_EN
    @(negedge clk);
    pend[1] = 1'b0; drive();
    #1;
    chk("tmo_done", 32'(bus.done), 1);
    chk("tmo_err", 32'(bus.err), 1);
    chk("tmo_done_id", 32'(bus.done_id), 1);
    @(negedge clk); #1;
    chk("tmo_idle_busy", 32'(bus.busy), 0);
    chk("tmo_idle_err", 32'(bus.err), 0);
`else
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      chk("stuck_busy", 32'(bus.busy), 1);
      chk("stuck_done", 32'(bus.done), 0);
    end
    reset_pulse();
`endif

    // Pointer back to requester 0 after reset.
    reset_pulse();
    setjob(0, 8'h08, 1); setjob(1, 8'h09, 1); drive(); serve(0, 1, 0, 1);
    @(negedge clk); drive(); serve(0, 1, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
